// File: rtl/pipeline_hazard_ctrl_pkg.sv
// Shared definitions for the 5-stage core's stall/flush controller.
package pipeline_hazard_ctrl_pkg;

    localparam int unsigned ST_W = 2;

    localparam logic [ST_W-1:0] ST_IDLE  = 2'd0;
    localparam logic [ST_W-1:0] ST_RUN   = 2'd1;
    localparam logic [ST_W-1:0] ST_STALL = 2'd2;
    localparam logic [ST_W-1:0] ST_FLUSH = 2'd3;

    // Instruction IF_ID loads when flushed (addi x0, x0, 0)
    localparam logic [31:0] NOP_INSTR = 32'h00000013;

    // Per-cycle pipeline-register control bundle
    typedef struct packed {
        logic pc_en;
        logic if_id_en;
        logic if_id_flush;
        logic id_ex_flush;
    } pipe_ctrl_t;

    function automatic int unsigned max_u(input int unsigned a, input int unsigned b);
        return (a > b) ? a : b;
    endfunction

endpackage

// File: rtl/pipeline_hazard_ctrl_hazard_detect.sv
// Load-use hazard detector: ID-stage sources against a load's destination.
module pipeline_hazard_ctrl_hazard_detect
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_W = 5
) (
    input  logic [REG_W-1:0] rs1_id,
    input  logic [REG_W-1:0] rs2_id,
    input  logic             uses_rs2_id,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             mem_read_ex,
    output logic             lu_c
);

    // x0 is never a real destination, so it cannot create a hazard
    always_comb begin
        lu_c = mem_read_ex && (rd_ex != '0) &&
               ((rd_ex == rs1_id) || (uses_rs2_id && (rd_ex == rs2_id)));
    end

endmodule

// File: rtl/pipeline_hazard_ctrl.sv
// Central stall/flush controller with saturating performance counters.
module pipeline_hazard_ctrl
    import pipeline_hazard_ctrl_pkg::*;
#(
    parameter int unsigned REG_W        = 5,
    parameter int unsigned CNT_W        = 32,
    parameter int unsigned STALL_CYCLES = 1,
    parameter int unsigned FLUSH_CYCLES = 1
) (
    input  logic             clk,
    input  logic             arst_n,
    input  logic             enable,
    input  logic [REG_W-1:0] rs1_id,
    input  logic [REG_W-1:0] rs2_id,
    input  logic             uses_rs2_id,
    input  logic [REG_W-1:0] rd_ex,
    input  logic             mem_read_ex,
    input  logic             redirect_ex,
    output logic             pc_en,
    output logic             if_id_en,
    output logic             if_id_flush,
    output logic             id_ex_flush,
    output logic             busy,
    output logic [CNT_W-1:0] cycle_cnt,
    output logic [CNT_W-1:0] stall_cnt,
    output logic [CNT_W-1:0] redirect_cnt
);

    localparam int unsigned DC_W      = $clog2(max_u(STALL_CYCLES, FLUSH_CYCLES)) + 1;
    localparam bit          MULTI_STL = (STALL_CYCLES > 1);
    localparam bit          MULTI_FLS = (FLUSH_CYCLES > 1);

    logic [ST_W-1:0] state, state_nxt;
    logic [DC_W-1:0] dcnt, dcnt_nxt;
    logic            inc_cyc, inc_stall, inc_red;
    logic            lu_c;
    pipe_ctrl_t      ctrl_c;

    pipeline_hazard_ctrl_hazard_detect #(.REG_W(REG_W)) u_hazard_detect (
        .rs1_id      (rs1_id),
        .rs2_id      (rs2_id),
        .uses_rs2_id (uses_rs2_id),
        .rd_ex       (rd_ex),
        .mem_read_ex (mem_read_ex),
        .lu_c        (lu_c)
    );

    // Next state, down-counter and pipeline controls; a dropped enable freezes the pipe
    always_comb begin
        state_nxt = state;
        dcnt_nxt  = dcnt;
        ctrl_c    = '0;
        inc_cyc   = 1'b0;
        inc_stall = 1'b0;
        inc_red   = 1'b0;
        if (!enable) begin
            state_nxt = ST_IDLE;
            dcnt_nxt  = '0;
        end else if (state == ST_IDLE) begin
            state_nxt = ST_RUN;
        end else begin
            inc_cyc = 1'b1;
            if (redirect_ex) begin
                ctrl_c  = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1};
                inc_red = 1'b1;
                if (MULTI_FLS) begin
                    state_nxt = ST_FLUSH;
                    dcnt_nxt  = DC_W'(FLUSH_CYCLES - 1);
                end else begin
                    state_nxt = ST_RUN;
                    dcnt_nxt  = '0;
                end
            end else if (state == ST_FLUSH) begin
                ctrl_c   = '{pc_en: 1'b1, if_id_en: 1'b1, if_id_flush: 1'b1, id_ex_flush: 1'b1};
                dcnt_nxt = dcnt - DC_W'(1);
                if (dcnt == DC_W'(1)) state_nxt = ST_RUN;
            end else if ((state == ST_STALL) || lu_c) begin
                ctrl_c.id_ex_flush = 1'b1;
                inc_stall          = 1'b1;
                if (state == ST_STALL) begin
                    dcnt_nxt = dcnt - DC_W'(1);
                    if (dcnt == DC_W'(1)) state_nxt = ST_RUN;
                end else if (MULTI_STL) begin
                    state_nxt = ST_STALL;
                    dcnt_nxt  = DC_W'(STALL_CYCLES - 1);
                end
            end else begin
                ctrl_c.pc_en    = 1'b1;
                ctrl_c.if_id_en = 1'b1;
            end
        end
    end

    // Controls are combinational from state and inputs
    always_comb begin
        pc_en       = ctrl_c.pc_en;
        if_id_en    = ctrl_c.if_id_en;
        if_id_flush = ctrl_c.if_id_flush;
        id_ex_flush = ctrl_c.id_ex_flush;
        busy        = (state == ST_STALL) || (state == ST_FLUSH);
    end

    // State, down-counter and saturating performance counters
    always_ff @(posedge clk) begin
        if (!arst_n) begin
            state        <= ST_IDLE;
            dcnt         <= '0;
            cycle_cnt    <= '0;
            stall_cnt    <= '0;
            redirect_cnt <= '0;
        end else begin
            state <= state_nxt;
            dcnt  <= dcnt_nxt;
            if (inc_cyc && (cycle_cnt != '1))    cycle_cnt    <= cycle_cnt + CNT_W'(1);
            if (inc_stall && (stall_cnt != '1))  stall_cnt    <= stall_cnt + CNT_W'(1);
            if (inc_red && (redirect_cnt != '1)) redirect_cnt <= redirect_cnt + CNT_W'(1);
        end
    end

endmodule
